// File: rtl/gpu_pkg.sv
// Shared GPU-side types and constants for the VRAM write path.
package gpu_pkg;

  localparam int VRAM_ADDR_WIDTH = 12;

  typedef struct packed {
    logic [VRAM_ADDR_WIDTH-1:0] addr;
    logic [7:0]                 data;
  } vram_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DMA   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/sync_fifo_m.sv
// Single-clock FIFO with wrap-bit pointers; read data is the current head.
module sync_fifo_m #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == FULL_CNT);
  assign o_empty   = (o_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates buffered CPU VRAM writes against burst DMA, presenting at most one
// write beat per cycle and only while the GPU write window is open.
module vram_write_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int CPU_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writable,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_data,
  output logic                  cpu_full,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [7:0]            dma_data,
  input  logic                  dma_last,
  output logic                  dma_grant,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]            vram_data,
  output logic                  vram_we,
  output logic                  busy,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int CW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(CPU_BURST + 1);

  arb_state_t              r_state;
  arb_state_t              w_act_state;
  arb_state_t              w_next_state;
  owner_t                  r_last_owner;
  owner_t                  w_next_owner;
  logic [BCW-1:0]          r_burst_cnt;
  logic [BCW-1:0]          w_next_burst_cnt;
  logic                    r_valid;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_data;
  logic                    r_overflow;
  logic                    w_load_ok;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_grant;
  logic                    w_dma_take;
  logic                    w_drain_exit;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [CW:0]             w_fifo_count;
  logic [ADDR_WIDTH+7:0]   w_fifo_rdata;

  // Handshakes: a CPU beat is taken when cpu_we & !cpu_full, a DMA beat when
  // dma_req & dma_grant, and a VRAM beat retires when vram_we; all in one cycle.
  assign w_load_ok  = ~r_valid | writable;
  assign w_push     = cpu_we & ~w_fifo_full;
  assign w_dma_take = w_grant & dma_req;

  sync_fifo_m #(
    .WIDTH(ADDR_WIDTH + 8),
    .DEPTH(FIFO_DEPTH)
  ) u_cpu_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_wdata({cpu_addr, cpu_data}),
    .i_pop  (w_pop),
    .o_rdata(w_fifo_rdata),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_owner <= OWNER_DMA;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_owner <= w_next_owner;
      r_burst_cnt  <= w_next_burst_cnt;
    end
  end

  // IDLE decides and hands the port over in the same cycle, so neither
  // requester loses a cycle to the arbitration decision.
  always_comb begin
    w_act_state      = r_state;
    w_next_owner     = r_last_owner;
    w_next_burst_cnt = r_burst_cnt;
    w_drain_exit     = 1'b0;
    if (r_state == IDLE && w_load_ok && writable) begin
      if (!w_fifo_empty && (r_last_owner == OWNER_DMA || !dma_req)) w_act_state = DRAIN;
      else if (dma_req) w_act_state = DMA;
    end
    w_next_state = w_act_state;
    if (w_load_ok) begin
      case (w_act_state)
        DRAIN: begin
          w_drain_exit = ~writable | w_fifo_empty
                       | (r_burst_cnt == BCW'(CPU_BURST - 1))
                       | ((w_fifo_count == (CW+1)'(1)) & ~w_push);
          if (w_drain_exit) begin
            w_next_state     = IDLE;
            w_next_owner     = OWNER_CPU;
            w_next_burst_cnt = '0;
          end else begin
            w_next_burst_cnt = r_burst_cnt + BCW'(1);
          end
        end
        DMA: begin
          if (writable && dma_req && dma_last) begin
            w_next_state = IDLE;
            w_next_owner = OWNER_DMA;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pop   = 1'b0;
    w_grant = 1'b0;
    if (w_load_ok && writable) begin
      case (w_act_state)
        DRAIN:   w_pop   = ~w_fifo_empty;
        DMA:     w_grant = 1'b1;
        default: ;
      endcase
    end
  end

  // Out-register: a held beat stays untouched until the window reopens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_valid          <= 1'b1;
      {r_addr, r_data} <= w_fifo_rdata;
    end else if (w_dma_take) begin
      r_valid <= 1'b1;
      r_addr  <= dma_addr;
      r_data  <= dma_data;
    end else if (vram_we) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_overflow <= 1'b0;
    else if (cpu_we && w_fifo_full) r_overflow <= 1'b1;
  end

  assign cpu_full  = w_fifo_full;
  assign dma_grant = w_grant;
  assign vram_we   = r_valid & writable;
  assign vram_addr = r_addr;
  assign vram_data = r_data;
  assign busy      = ~w_fifo_empty | r_valid | (r_state != IDLE);
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule
